// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers pixel/line counters from active-low VGA syncs,
// measures line, frame and pulse widths, and reports lock when the timing
// matches the expected mode for LOCK_FRAMES consecutive frames.
module vga_sync_rx #(
    parameter int unsigned EXP_HTOTAL  = 800,
    parameter int unsigned EXP_VTOTAL  = 525,
    parameter int unsigned EXP_HSW     = 96,
    parameter int unsigned EXP_VSW     = 2,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic       pck,
    input  logic       rst,
    input  logic       vga_hs,
    input  logic       vga_vs,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic [9:0] h_total,
    output logic [9:0] v_total,
    output logic [9:0] hs_width,
    output logic [9:0] vs_width,
    output logic       locked,
    output logic       frame_pulse,
    output logic       err_pulse
);

    localparam int unsigned CW = 10;
    localparam int unsigned GW = 4;
    localparam logic [CW-1:0] CMAX   = '1;
    localparam logic [CW-1:0] HT_E   = CW'(EXP_HTOTAL);
    localparam logic [CW-1:0] VT_E   = CW'(EXP_VTOTAL);
    localparam logic [CW-1:0] HSW_E  = CW'(EXP_HSW);
    localparam logic [CW-1:0] VSW_E  = CW'(EXP_VSW);
    localparam logic [GW-1:0] LOCK_N = GW'(LOCK_FRAMES);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CMAX) ? v : v + CW'(1);
    endfunction

    logic          r_hs_q;
    logic          r_vs_line;
    logic [CW-1:0] r_hs_low;
    logic [CW-1:0] r_vs_low;
    logic          r_frame_bad;
    logic [1:0]    r_state;
    logic [GW-1:0] r_good;

    logic          w_hs_fall;
    logic          w_hs_rise;
    logic          w_vs_fall;
    logic          w_vs_rise;
    logic [CW-1:0] w_hcnt_inc;
    logic [CW-1:0] w_vcnt_inc;
    logic [CW-1:0] w_hsl_inc;
    logic [CW-1:0] w_vsl_inc;
    logic          w_sync_lost;
    logic          w_frame_ok;
    logic          w_chk_fail;
    logic [1:0]    w_state_nxt;
    logic [GW-1:0] w_good_nxt;
    logic          w_locked_nxt;
    logic          w_err_nxt;

    // vs is only looked at on hs falling edges, so it is line-qualified
    assign w_hs_fall   = r_hs_q & ~vga_hs;
    assign w_hs_rise   = ~r_hs_q & vga_hs;
    assign w_vs_fall   = w_hs_fall & r_vs_line & ~vga_vs;
    assign w_vs_rise   = w_hs_fall & ~r_vs_line & vga_vs;
    assign w_hcnt_inc  = sat_inc(hcnt);
    assign w_vcnt_inc  = sat_inc(vcnt);
    assign w_hsl_inc   = sat_inc(r_hs_low);
    assign w_vsl_inc   = sat_inc(r_vs_low);
    assign w_sync_lost = (hcnt == CMAX);
    assign w_frame_ok  = ~r_frame_bad & (w_vcnt_inc == VT_E) & (w_hcnt_inc == HT_E);
    assign w_chk_fail  = (w_hs_fall & (w_hcnt_inc != HT_E))
                       | (w_hs_rise & (w_hsl_inc != HSW_E))
                       | (w_vs_rise & (r_vs_low != VSW_E));

    // Sync edge history
    always_ff @(posedge pck or posedge rst) begin
        if (rst) begin
            r_hs_q    <= 1'b1;
            r_vs_line <= 1'b1;
        end else begin
            r_hs_q <= vga_hs;
            if (w_hs_fall) r_vs_line <= vga_vs;
        end
    end

    // Pixel counter and line length
    always_ff @(posedge pck or posedge rst) begin
        if (rst) begin
            hcnt    <= '0;
            h_total <= '0;
        end else if (w_hs_fall) begin
            hcnt    <= '0;
            h_total <= w_hcnt_inc;
        end else begin
            hcnt    <= w_hcnt_inc;
        end
    end

    // hs low-time measurement
    always_ff @(posedge pck or posedge rst) begin
        if (rst) begin
            r_hs_low <= '0;
            hs_width <= '0;
        end else begin
            if (w_hs_fall)   r_hs_low <= '0;
            else if (!vga_hs) r_hs_low <= w_hsl_inc;
            if (w_hs_rise)   hs_width <= w_hsl_inc;
        end
    end

    // Line counter and frame length
    always_ff @(posedge pck or posedge rst) begin
        if (rst) begin
            vcnt    <= '0;
            v_total <= '0;
        end else if (w_vs_fall) begin
            vcnt    <= '0;
            v_total <= w_vcnt_inc;
        end else if (w_hs_fall) begin
            vcnt    <= w_vcnt_inc;
        end
    end

    // vs low-time in lines; the line that sees vs fall is the first low line
    always_ff @(posedge pck or posedge rst) begin
        if (rst) begin
            r_vs_low <= '0;
            vs_width <= '0;
        end else begin
            if (w_vs_fall)                 r_vs_low <= CW'(1);
            else if (w_hs_fall && !vga_vs) r_vs_low <= w_vsl_inc;
            if (w_vs_rise)                 vs_width <= r_vs_low;
        end
    end

    // Sticky per-frame error flag, restarted at each frame boundary
    always_ff @(posedge pck or posedge rst) begin
        if (rst)            r_frame_bad <= 1'b0;
        else if (w_vs_fall) r_frame_bad <= 1'b0;
        else if (w_chk_fail) r_frame_bad <= 1'b1;
    end

    // Lock FSM state and registered status outputs
    always_ff @(posedge pck or posedge rst) begin
        if (rst) begin
            r_state     <= ST_SEARCH;
            r_good      <= '0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            frame_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_good      <= w_good_nxt;
            locked      <= w_locked_nxt;
            err_pulse   <= w_err_nxt;
            frame_pulse <= w_vs_fall;
        end
    end

    // Lock FSM next state; a saturated hcnt overrides any edge activity
    always_comb begin
        w_state_nxt  = r_state;
        w_good_nxt   = r_good;
        w_locked_nxt = locked;
        w_err_nxt    = 1'b0;
        if (w_sync_lost) begin
            w_state_nxt  = ST_SEARCH;
            w_good_nxt   = '0;
            w_locked_nxt = 1'b0;
        end else if (w_vs_fall) begin
            case (r_state)
                ST_SEARCH: begin
                    w_state_nxt = ST_CHECK;
                    w_good_nxt  = '0;
                end
                ST_CHECK: begin
                    if (w_frame_ok) begin
                        w_good_nxt = r_good + GW'(1);
                        if (r_good + GW'(1) == LOCK_N) begin
                            w_state_nxt  = ST_LOCKED;
                            w_locked_nxt = 1'b1;
                        end
                    end else begin
                        w_good_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!w_frame_ok) begin
                        w_state_nxt  = ST_CHECK;
                        w_good_nxt   = '0;
                        w_locked_nxt = 1'b0;
                        w_err_nxt    = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt  = ST_SEARCH;
                    w_good_nxt   = '0;
                    w_locked_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: drives a scaled-down VGA sync generator into vga_sync_rx
// and checks frame-boundary measurements and lock status via a scoreboard.
module tb_vga_sync_rx;

    localparam int HT     = 100;
    localparam int VT     = 8;
    localparam int HSW    = 12;
    localparam int VSW    = 2;
    localparam int LOCKN  = 2;
    localparam int GAP_HI = 1100;

    logic       pck;
    logic       rst;
    logic       vga_hs;
    logic       vga_vs;
    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic [9:0] h_total;
    logic [9:0] v_total;
    logic [9:0] hs_width;
    logic [9:0] vs_width;
    logic       locked;
    logic       frame_pulse;
    logic       err_pulse;

    typedef struct {
        int ht;
        int vt;
        int hsw;
        int vsw;
        int lk;
        int er;
        int per;
        bit full;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int last_fp  = -1;
    int last_vsw = 0;

    vga_sync_rx #(
        .EXP_HTOTAL (HT),
        .EXP_VTOTAL (VT),
        .EXP_HSW    (HSW),
        .EXP_VSW    (VSW),
        .LOCK_FRAMES(LOCKN)
    ) dut (
        .pck        (pck),
        .rst        (rst),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .h_total    (h_total),
        .v_total    (v_total),
        .hs_width   (hs_width),
        .vs_width   (vs_width),
        .locked     (locked),
        .frame_pulse(frame_pulse),
        .err_pulse  (err_pulse)
    );

    initial pck = 1'b0;
    always #5 pck = ~pck;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Compare DUT frame-boundary outputs against the oldest pending expectation
    task automatic monitor();
        exp_t e;
        if (rst) return;
        if (frame_pulse) begin
            check_eq("sb_avail", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("h_total", int'(h_total), e.ht);
                if (e.full) check_eq("v_total", int'(v_total), e.vt);
                check_eq("hs_width", int'(hs_width), e.hsw);
                check_eq("vs_width", int'(vs_width), e.vsw);
                check_eq("locked", int'(locked), e.lk);
                check_eq("err_pulse", int'(err_pulse), e.er);
                if (e.full && last_fp >= 0) check_eq("frame_period", cyc - last_fp, e.per);
            end
            last_fp = cyc;
        end else if (err_pulse) begin
            check_eq("err_stray", int'(err_pulse), 0);
        end
    endtask

    task automatic tick();
        @(posedge pck);
        #1;
        cyc++;
        monitor();
    endtask

    task automatic chk_zero(input string tag);
        check_eq({tag, ".hcnt"},        int'(hcnt), 0);
        check_eq({tag, ".vcnt"},        int'(vcnt), 0);
        check_eq({tag, ".h_total"},     int'(h_total), 0);
        check_eq({tag, ".v_total"},     int'(v_total), 0);
        check_eq({tag, ".hs_width"},    int'(hs_width), 0);
        check_eq({tag, ".vs_width"},    int'(vs_width), 0);
        check_eq({tag, ".locked"},      int'(locked), 0);
        check_eq({tag, ".frame_pulse"}, int'(frame_pulse), 0);
        check_eq({tag, ".err_pulse"},   int'(err_pulse), 0);
    endtask

    task automatic drive_line(input int htot, input int hsw, input bit vs_lo);
        vga_hs = 1'b0;
        vga_vs = !vs_lo;
        repeat (hsw) tick();
        vga_hs = 1'b1;
        repeat (htot - hsw) tick();
    endtask

    // Line whose hs stays high for GAP_HI clocks, exercising saturation
    task automatic drive_gap_line();
        vga_hs = 1'b0;
        vga_vs = 1'b1;
        repeat (HSW) tick();
        vga_hs = 1'b1;
        repeat (1023 - HSW) tick();
        check_eq("gap_hcnt_pre", int'(hcnt), 1022);
        tick();
        check_eq("sat_hcnt", int'(hcnt), 1023);
        check_eq("lk_at_sat", int'(locked), 1);
        tick();
        check_eq("sat_hold", int'(hcnt), 1023);
        check_eq("lk_lost", int'(locked), 0);
        repeat (GAP_HI - (1023 - HSW) - 2) tick();
    endtask

    // Drive one frame; push what the boundary that ends it must report
    task automatic drive_frame(input int nl, input int vsw, input int bad_line,
                               input int b_ht, input int b_hsw, input bit gap,
                               input int lk, input int er, input bit full);
        exp_t e;
        int dur  = 0;
        int lht  = HT;
        int lhsw = HSW;
        for (int l = 0; l < nl; l++) begin
            int ht = HT;
            int hs = HSW;
            if (l == bad_line && gap) begin
                drive_gap_line();
                ht = HSW + GAP_HI;
            end else begin
                if (l == bad_line) begin
                    ht = b_ht;
                    hs = b_hsw;
                end
                drive_line(ht, hs, l < vsw);
            end
            dur += ht;
            lht  = ht;
            lhsw = hs;
        end
        if (vsw > 0) last_vsw = vsw;
        e.ht   = lht;
        e.vt   = nl;
        e.hsw  = lhsw;
        e.vsw  = last_vsw;
        e.lk   = lk;
        e.er   = er;
        e.per  = dur;
        e.full = full;
        sb.push_back(e);
    endtask

    task automatic good_frame(input int lk);
        drive_frame(VT, VSW, -1, 0, 0, 1'b0, lk, 0, 1'b1);
    endtask

    initial begin
        rst    = 1'b1;
        vga_hs = 1'b1;
        vga_vs = 1'b1;
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        repeat (30) tick();

        // Acquire: partial tail, then two good frames
        drive_frame(3, 0, -1, 0, 0, 1'b0, 0, 0, 1'b0);
        good_frame(0);
        good_frame(1);

        // One stretched line while locked
        drive_frame(VT, VSW, VT - 1, HT + 1, HSW, 1'b0, 0, 1, 1'b1);
        good_frame(0);
        good_frame(1);

        // One hs pulse too wide while locked
        drive_frame(VT, VSW, VT - 1, HT, HSW + 1, 1'b0, 0, 1, 1'b1);
        good_frame(0);
        good_frame(1);

        // vs held low three lines
        drive_frame(VT, 3, -1, 0, 0, 1'b0, 0, 1, 1'b1);
        good_frame(0);
        good_frame(1);

        // hs stuck high mid-frame: sync loss then reacquire
        drive_frame(VT, VSW, 3, 0, 0, 1'b1, 0, 0, 1'b1);
        good_frame(0);
        good_frame(1);

        // Asynchronous reset mid-line while locked
        drive_line(HT, HSW, 1'b1);
        drive_line(HT, HSW, 1'b1);
        drive_line(HT, HSW, 1'b0);
        vga_hs = 1'b0;
        repeat (HSW) tick();
        vga_hs = 1'b1;
        repeat (20) tick();
        check_eq("lk_pre_rst", int'(locked), 1);
        rst = 1'b1;
        #2;
        chk_zero("async_rst");
        repeat (3) tick();
        rst      = 1'b0;
        last_vsw = 0;
        tick();
        check_eq("hcnt_resume1", int'(hcnt), 1);
        tick();
        check_eq("hcnt_resume2", int'(hcnt), 2);
        repeat (30) tick();
        drive_frame(3, 0, -1, 0, 0, 1'b0, 0, 0, 1'b0);
        good_frame(0);
        good_frame(1);
        good_frame(1);

        // Start one more frame so the last boundary is reported
        drive_line(HT, HSW, 1'b1);
        repeat (5) tick();
        check_eq("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
